// File: rtl/multicycle_controller.sv
// Multicycle FSM controller: fetch/decode/exec/mem/wb, 4-5 cycles per instruction plus memory wait.
// Holds imem_req/mem_req until ack; a stall of MEM_TIMEOUT cycles traps in a sticky ERROR state.
module multicycle_controller #(
    parameter logic [7:0] PC_RESET    = 8'h00,
    parameter int         MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] instr,
    output logic       imem_req,
    input  logic       imem_ack,
    output logic [7:0] pc,
    output logic [1:0] rs1_addr,
    output logic [1:0] rs2_addr,
    output logic [1:0] wr_addr,
    output logic       reg_wr_en,
    output logic [1:0] alu_op,
    output logic [1:0] imm,
    output logic       alu_src,
    output logic       mem_req,
    output logic       mem_we,
    input  logic       mem_ack,
    output logic       wb_sel,
    output logic       busy,
    output logic       error,
    output logic [7:0] instr_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    localparam logic [1:0] OP_R     = 2'b00;
    localparam logic [1:0] OP_I     = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    // Value of the wait counter during the last tolerated stall cycle.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] wait_q, wait_d;
    logic       stop_pend_q, stop_pend_d;

    logic [1:0] op, rd, rs, lo;
    logic       is_busy, timed_out, retire;

    assign op = ir_q[7:6];
    assign rd = ir_q[5:4];
    assign rs = ir_q[3:2];
    assign lo = ir_q[1:0];

    assign is_busy   = (state_q != S_IDLE) && (state_q != S_ERROR);
    assign timed_out = (wait_q == WAIT_LAST);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        cnt_d       = cnt_q;
        wait_d      = 8'd0;
        stop_pend_d = stop_pend_q | (is_busy & stop);
        retire      = 1'b0;
        case (state_q)
            S_IDLE:   if (start && !stop) state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = instr;
                    pc_d    = pc_q + 8'd1;
                    state_d = S_DECODE;
                end else if (timed_out) begin
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = op[1] ? S_MEM : S_WB;
            S_MEM: begin
                if (mem_ack) begin
                    if (op == OP_STORE) retire = 1'b1;
                    else                state_d = S_WB;
                end else if (timed_out) begin
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB:     retire = 1'b1;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_IDLE;
        endcase
        if (retire) begin
            cnt_d   = cnt_q + 8'd1;
            state_d = (stop_pend_q || stop) ? S_IDLE : S_FETCH;
        end
        if (state_d == S_IDLE) stop_pend_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            pc_q        <= PC_RESET;
            ir_q        <= 8'd0;
            cnt_q       <= 8'd0;
            wait_q      <= 8'd0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    // Outputs are Moore (state + IR only), so reset clears them without a clock edge.
    always_comb begin
        rs1_addr = 2'b00;
        rs2_addr = 2'b00;
        wr_addr  = 2'b00;
        alu_op   = 2'b00;
        imm      = 2'b00;
        alu_src  = 1'b0;
        wb_sel   = 1'b0;
        if (state_q == S_DECODE || state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            case (op)
                OP_R: begin
                    rs1_addr = rd;
                    rs2_addr = rs;
                    alu_op   = lo;
                    wr_addr  = rd;
                end
                OP_I: begin
                    rs1_addr = rd;
                    alu_op   = rs;
                    imm      = lo;
                    alu_src  = 1'b1;
                    wr_addr  = rd;
                end
                OP_LOAD: begin
                    rs1_addr = rs;
                    imm      = lo;
                    alu_src  = 1'b1;
                    wr_addr  = rd;
                    wb_sel   = 1'b1;
                end
                default: begin
                    rs1_addr = rs;
                    rs2_addr = rd;
                    imm      = lo;
                    alu_src  = 1'b1;
                end
            endcase
        end
    end

    assign imem_req    = (state_q == S_FETCH);
    assign mem_req     = (state_q == S_MEM);
    assign mem_we      = (state_q == S_MEM) && (op == OP_STORE);
    assign reg_wr_en   = (state_q == S_WB);
    assign busy        = is_busy;
    assign error       = (state_q == S_ERROR);
    assign pc          = pc_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: decode table, randomized instruction stream vs. a
// transaction-level model, plus stop/wrap, timeout and asynchronous-reset sequences.
module tb_multicycle_controller;

    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0, stop = 1'b0;
    logic [7:0] instr = 8'd0;
    logic       imem_req, imem_ack = 1'b0;
    logic [7:0] pc;
    logic [1:0] rs1_addr, rs2_addr, wr_addr, alu_op, imm;
    logic       reg_wr_en, alu_src, mem_req, mem_we, mem_ack = 1'b0;
    logic       wb_sel, busy, error;
    logic [7:0] instr_count;

    multicycle_controller #(.PC_RESET(8'h00), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .instr(instr),
        .imem_req(imem_req), .imem_ack(imem_ack), .pc(pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .wr_addr(wr_addr),
        .reg_wr_en(reg_wr_en), .alu_op(alu_op), .imm(imm), .alu_src(alu_src),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack), .wb_sel(wb_sel),
        .busy(busy), .error(error), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] rs1, rs2, wr, aop, imm;
        logic       asrc, wbs;
    } dec_t;

    typedef struct {
        logic [7:0] ins;
        int         fw;
        int         mw;
        dec_t       exp;
    } vec_t;

    int         checks = 0, failures = 0;
    logic [7:0] pc_m = 8'h00, cnt_m = 8'h00;
    vec_t       vecs[7];

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic dec_t mk(input logic [1:0] r1, r2, w, a, i, input logic s, b);
        return dec_t'({r1, r2, w, a, i, s, b});
    endfunction

    function automatic dec_t obs_dec();
        return dec_t'({rs1_addr, rs2_addr, wr_addr, alu_op, imm, alu_src, wb_sel});
    endfunction

    // Field meanings straight from the instruction-format table.
    function automatic dec_t ref_dec(input logic [7:0] ins);
        logic [1:0] rd, rs, lo;
        rd = ins[5:4];
        rs = ins[3:2];
        lo = ins[1:0];
        case (ins[7:6])
            2'b00:   return mk(rd, rs, rd, lo, 2'b00, 1'b0, 1'b0);
            2'b01:   return mk(rd, 2'b00, rd, rs, lo, 1'b1, 1'b0);
            2'b10:   return mk(rs, 2'b00, rd, 2'b00, lo, 1'b1, 1'b1);
            default: return mk(rs, rd, 2'b00, 2'b00, lo, 1'b1, 1'b0);
        endcase
    endfunction

    // Runs one instruction starting from a FETCH cycle; fw/mw are stall cycles before each ack.
    task automatic exec_instr(input logic [7:0] ins, input int fw, input int mw,
                              input bit stop_exec, input bit spur, input dec_t exp);
        int         lat, mcnt, wcnt, exp_lat;
        bit         fz_bad, dec_bad, we_bad, done, is_mem, is_st;
        logic [7:0] cnt0;
        fz_bad = 0; dec_bad = 0; we_bad = 0; done = 0; mcnt = 0; wcnt = 0;
        is_mem = ins[7];
        is_st  = (ins[7:6] == 2'b11);
        exp_lat = is_mem ? (is_st ? 4 + mw : 5 + mw) : 4;
        chk("pc_at_fetch", pc, pc_m);
        for (int i = 0; i < fw; i++) begin
            if (!imem_req || obs_dec() != '0 || !busy) fz_bad = 1;
            tick();
        end
        if (!imem_req || obs_dec() != '0) fz_bad = 1;
        imem_ack = 1'b1;
        instr    = ins;
        cnt0     = instr_count;
        tick();
        imem_ack = 1'b0;
        instr    = 8'($urandom);
        lat = 1;
        for (int c = 0; c < 64 && !done; c++) begin
            if (obs_dec() != exp || imem_req || !busy) dec_bad = 1;
            if (mem_req) begin
                mcnt++;
                if (mem_we != is_st) we_bad = 1;
                mem_ack = (mcnt > mw);
            end else begin
                if (mem_we) we_bad = 1;
                mem_ack = spur && (c == 0);
            end
            if (reg_wr_en) wcnt++;
            imem_ack = spur && (c == 0);
            start    = spur && (c == 0);
            stop     = stop_exec && (c == 1);
            lat++;
            tick();
            mem_ack = 1'b0; imem_ack = 1'b0; start = 1'b0; stop = 1'b0;
            if (instr_count != cnt0) done = 1;
        end
        pc_m  = pc_m + 8'd1;
        cnt_m = cnt_m + 8'd1;
        chk("fetch_outputs", fz_bad, 0);
        chk("decode_fields", dec_bad, 0);
        chk("latency", lat, exp_lat);
        chk("mem_req_cycles", mcnt, is_mem ? mw + 1 : 0);
        chk("mem_we", we_bad, 0);
        chk("reg_wr_cycles", wcnt, is_st ? 0 : 1);
        chk("pc_after", pc, pc_m);
        chk("instr_count", instr_count, cnt_m);
        chk("busy_after", busy, !stop_exec);
        chk("imem_req_after", imem_req, !stop_exec);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_error", error, 0);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_pc", pc, 0);
        chk("rst_count", instr_count, 0);
        tick();
        reset = 1'b1;
        pc_m  = 8'h00;
        cnt_m = 8'h00;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         fw, mw, guard, mcnt;
        bit         se;
        logic [7:0] ins;

        vecs[0] = '{8'b00_01_10_01, 1, 0, mk(2'd1, 2'd2, 2'd1, 2'd1, 2'd0, 1'b0, 1'b0)};
        vecs[1] = '{8'b10_11_00_10, 0, 3, mk(2'd0, 2'd0, 2'd3, 2'd0, 2'd2, 1'b1, 1'b1)};
        vecs[2] = '{8'b11_00_01_11, 2, 0, mk(2'd1, 2'd0, 2'd0, 2'd0, 2'd3, 1'b1, 1'b0)};
        vecs[3] = '{8'b01_10_11_01, 0, 0, mk(2'd2, 2'd0, 2'd2, 2'd3, 2'd1, 1'b1, 1'b0)};
        vecs[4] = '{8'b00_11_01_10, 3, 0, mk(2'd3, 2'd1, 2'd3, 2'd2, 2'd0, 1'b0, 1'b0)};
        vecs[5] = '{8'b11_10_11_00, 0, 2, mk(2'd3, 2'd2, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0)};
        vecs[6] = '{8'b10_01_10_11, TO - 1, TO - 1, mk(2'd2, 2'd0, 2'd1, 2'd0, 2'd3, 1'b1, 1'b1)};

        // Reset state, held across clock edges.
        #3;
        chk("por_pc", pc, 0);
        chk("por_busy", busy, 0);
        chk("por_imem_req", imem_req, 0);
        start = 1'b1;
        tick(); tick();
        chk("por_hold_busy", busy, 0);
        chk("por_hold_count", instr_count, 0);
        start = 1'b0;
        #2 reset = 1'b1;
        tick();

        // start together with stop is ignored.
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("start_with_stop", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_fetch", imem_req, 1);

        for (int v = 0; v < 7; v++)
            exec_instr(vecs[v].ins, vecs[v].fw, vecs[v].mw, 1'b0, 1'b0, vecs[v].exp);

        // Random stream until the next fetch address is 8'hFF.
        guard = 0;
        while (pc_m != 8'hFF && guard < 400) begin
            guard++;
            ins = 8'($urandom);
            fw  = ($urandom_range(0, 15) == 0) ? TO - 1 : $urandom_range(0, 4);
            mw  = ($urandom_range(0, 15) == 0) ? TO - 1 : $urandom_range(0, 6);
            se  = ($urandom_range(0, 9) == 0);
            exec_instr(ins, fw, mw, se, 1'($urandom_range(0, 1)), ref_dec(ins));
            if (se) begin
                tick();
                chk("stopped_idle", busy, 0);
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        chk("reached_pc_ff", pc_m, 8'hFF);

        // stop in EXEC at pc 8'hFF: retire, wrap pc and count, then idle.
        exec_instr(8'b00_01_10_01, 0, 0, 1'b1, 1'b0, vecs[0].exp);
        chk("wrap_pc", pc, 8'h00);
        tick();
        chk("wrap_idle", busy, 0);

        // Data-memory timeout.
        start = 1'b1;
        tick();
        start = 1'b0;
        imem_ack = 1'b1; instr = 8'b10_00_00_00;
        tick();
        imem_ack = 1'b0;
        pc_m = pc_m + 8'd1;
        tick(); tick();
        mcnt = 0;
        for (int c = 0; c < 40 && !error; c++) begin
            if (mem_req) mcnt++;
            tick();
        end
        chk("mem_to_req_cycles", mcnt, TO);
        chk("mem_to_error", error, 1);
        chk("mem_to_mem_req", mem_req, 0);
        chk("mem_to_reg_wr", reg_wr_en, 0);
        chk("mem_to_count", instr_count, cnt_m);
        chk("mem_to_fields", 32'(obs_dec()), 0);
        start = 1'b1;
        tick(); tick(); tick();
        start = 1'b0;
        chk("error_sticky", error, 1);
        chk("error_not_busy", busy, 0);
        chk("error_no_fetch", imem_req, 0);
        do_reset();

        // Instruction-fetch timeout: pc must not advance.
        start = 1'b1;
        tick();
        start = 1'b0;
        mcnt = 0;
        for (int c = 0; c < 40 && !error; c++) begin
            if (imem_req) mcnt++;
            tick();
        end
        chk("fetch_to_req_cycles", mcnt, TO);
        chk("fetch_to_error", error, 1);
        chk("fetch_to_pc", pc, pc_m);
        do_reset();

        // Asynchronous reset in the middle of a memory wait.
        start = 1'b1;
        tick();
        start = 1'b0;
        exec_instr(8'b01_00_00_00, 0, 0, 1'b0, 1'b0, ref_dec(8'b01_00_00_00));
        imem_ack = 1'b1; instr = 8'b10_11_00_10;
        tick();
        imem_ack = 1'b0;
        tick(); tick(); tick(); tick();
        chk("mid_mem_req", mem_req, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_mem_req", mem_req, 0);
        chk("async_pc", pc, 0);
        chk("async_count", instr_count, 0);
        chk("async_busy", busy, 0);
        chk("async_reg_wr", reg_wr_en, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("post_reset_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter PC_RESET, default 8'h00, PC value loaded on reset.
REQ-002 Parameter MEM_TIMEOUT, default 15, maximum wait cycles for imem_ack/mem_ack before ERROR.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-005 start  input  1  run request, sampled in IDLE only.
REQ-006 stop  input  1  halt request; honoured at the next instruction boundary.
REQ-007 instr  input  8  instruction word, valid when imem_ack=1.
REQ-008 imem_req  output  1  instruction fetch request; imem_ack  input  1  fetch done.
REQ-009 pc  output  8  instruction address.
REQ-010 rs1_addr, rs2_addr, wr_addr  output  2 each  register-file addresses.
REQ-011 reg_wr_en  output  1  register-file write strobe.
REQ-012 alu_op  output  2; imm  output  2; alu_src  output  1 (1 = immediate operand).
REQ-013 mem_req  output  1; mem_we  output  1; mem_ack  input  1  data-memory handshake.
REQ-014 wb_sel  output  1  write-back source, 0 = ALU result, 1 = memory data.
REQ-015 busy  output  1; error  output  1; instr_count  output  8  retired instructions.

Function
REQ-016 States: IDLE, FETCH, DECODE, EXEC, MEM, WB, ERROR; busy=1 in all states except IDLE and ERROR.
REQ-017 IDLE: start=1 and stop=0 -> FETCH next cycle; start with stop=1 same cycle ignored.
REQ-018 FETCH: imem_req=1 held until imem_ack=1; on ack IR<=instr, pc<=pc+1 (8'hFF wraps to 8'h00), -> DECODE.
REQ-019 IR fields: op=IR[7:6], rd=IR[5:4], rs=IR[3:2], lo=IR[1:0].
REQ-020 op 00 (R): rs1_addr=rd, rs2_addr=rs, alu_op=lo, alu_src=0, wr_addr=rd, wb_sel=0.
REQ-021 op 01 (I): rs1_addr=rd, alu_op=rs, imm=lo, alu_src=1, wr_addr=rd, wb_sel=0.
REQ-022 op 10 (LOAD): rs1_addr=rs, imm=lo, alu_op=2'b00, alu_src=1, wr_addr=rd, wb_sel=1.
REQ-023 op 11 (STORE): rs1_addr=rs, rs2_addr=rd (store data), imm=lo, alu_op=2'b00, alu_src=1.
REQ-024 Decoded outputs stable from DECODE through the last state of the instruction; 0 in IDLE/FETCH/ERROR.
REQ-025 DECODE -> EXEC unconditionally (1 cycle); EXEC lasts 1 cycle.
REQ-026 EXEC -> WB for R/I, -> MEM for LOAD/STORE.
REQ-027 MEM: mem_req=1 (mem_we=1 for STORE only) held until mem_ack=1; then LOAD -> WB, STORE -> instruction complete.
REQ-028 WB: reg_wr_en=1 for exactly one cycle; instruction complete at end of WB.
REQ-029 Latency from ack to completion: R/I 4 cycles incl. FETCH ack cycle; LOAD 5 + mem wait; STORE 4 + mem wait.
REQ-030 On completion: instr_count+1 (wraps 8'hFF->8'h00); -> IDLE if stop latched, else FETCH.
REQ-031 stop=1 in any busy cycle sets stop_pending; cleared on entry to IDLE.
REQ-032 Wait counter counts consecutive cycles in FETCH or MEM with ack=0; cleared on ack or state change.
REQ-033 Counter reaching MEM_TIMEOUT -> ERROR next cycle; imem_req/mem_req drop that cycle; instruction not retired, pc not advanced.
REQ-034 ERROR: error=1, all strobes 0, sticky; exit only by reset; start ignored.
REQ-035 ack arriving in the same cycle the counter reaches MEM_TIMEOUT: ack wins, normal progression.
REQ-036 start while busy ignored; acks outside FETCH/MEM ignored.

Reset
REQ-037 reset=0 asynchronously: state=IDLE, pc=PC_RESET, IR=0, instr_count=0, error=0, stop_pending=0, wait counter=0, all outputs 0.
REQ-038 Reset mid-MEM or mid-FETCH: mem_req/imem_req deassert without waiting for clk; no register write occurs.

Verification
REQ-039 start, instr=8'b00_01_10_01 acked 1 cycle later -> rs1=1, rs2=2, alu_op=01, wr_addr=1, reg_wr_en one cycle in WB, pc=8'h01, instr_count=1.
REQ-040 LOAD 8'b10_11_00_10, mem_ack after 3 wait cycles -> mem_req high 4 cycles, mem_we=0, wb_sel=1, wr_addr=3, imm=2.
REQ-041 STORE 8'b11_00_01_11 -> rs1=1, rs2=0, mem_we=1, no reg_wr_en, instr_count+1.
REQ-042 mem_ack withheld -> ERROR after 15 wait cycles, error=1, mem_req=0, start ignored until reset.
REQ-043 stop pulsed during EXEC of instruction at pc=8'hFF -> instruction completes, pc=8'h00, IDLE, busy=0.
REQ-044 reset asserted during MEM wait -> immediate IDLE, mem_req=0, pc=PC_RESET, instr_count=0.
